// File: rtl/divisor_normalizer.sv
// divisor_normalizer
//   Front end of the reciprocal datapath. Accepts a raw unsigned divisor, left-normalizes it
//   into [0.5,1) (Q0.W), forms the linear Newton-Raphson seed X0 = 48/17 - 32/17*Dn (Q2.30),
//   launches the downstream Newton stage via START/AVAILABLE/DONE and finally reports the
//   normalization shift so the result can be denormalized.
//
// Ports
//   clk, rstn      clock (rising edge), asynchronous active-low reset
//   div_valid/div_ready/div_in   divisor input handshake (ready only while idle)
//   nr_start, nr_in, nr_seed     START plus operands to the Newton stage (held while started)
//   nr_available, nr_done        Newton stage idle / finished
//   norm_shift, norm_valid       shift count applied to div_in, one-cycle completion pulse
//   busy                         high whenever not idle
//   div_zero                     only with DIVZERO_BYPASS_EN: zero divisor bypassed Newton
//
// Configuration
//   DIVZERO_BYPASS_EN  when defined, a zero divisor skips normalization and the Newton launch
//                      and completes at once with div_zero=1 and norm_shift=0.
module divisor_normalizer #(
  parameter int unsigned      W       = 32,
  parameter int unsigned      SHIFT_W = 5,
  parameter logic [W-1:0]     SEED_K0 = 32'hB4B4B4B4,
  parameter logic [W-1:0]     SEED_K1 = 32'h78787878
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               div_valid,
  output logic               div_ready,
  input  logic [W-1:0]       div_in,
  output logic               nr_start,
  output logic [W-1:0]       nr_in,
  output logic [W-1:0]       nr_seed,
  input  logic               nr_available,
  input  logic               nr_done,
  output logic [SHIFT_W-1:0] norm_shift,
  output logic               norm_valid,
  output logic               busy
`ifdef DIVZERO_BYPASS_EN
  ,
  output logic               div_zero
`endif
);

  typedef enum logic [2:0] {
    StIdle,
    StNorm,
    StSeed,
    StWait,
    StLaunch,
    StResp
  } state_e;

  localparam logic [SHIFT_W-1:0] CntMax = SHIFT_W'(W - 1);

  state_e             state_q, state_d;
  logic [W-1:0]       dreg_q, dreg_d;
  logic [SHIFT_W-1:0] cnt_q, cnt_d;
  logic [W-1:0]       nr_in_q, nr_in_d;
  logic [W-1:0]       nr_seed_q, nr_seed_d;
  logic               nr_start_q, nr_start_d;
  logic [SHIFT_W-1:0] norm_shift_q, norm_shift_d;
`ifdef DIVZERO_BYPASS_EN
  logic               div_zero_q, div_zero_d;
`endif

  // High word of the full-width product: (K1 * Dn) >> W, truncating.
  logic [W-1:0] seed_prod_hi;
  assign seed_prod_hi = W'(((2 * W)'(SEED_K1) * (2 * W)'(dreg_q)) >> W);

  always_comb begin
    state_d      = state_q;
    dreg_d       = dreg_q;
    cnt_d        = cnt_q;
    nr_in_d      = nr_in_q;
    nr_seed_d    = nr_seed_q;
    nr_start_d   = nr_start_q;
    norm_shift_d = norm_shift_q;
`ifdef DIVZERO_BYPASS_EN
    div_zero_d   = div_zero_q;
`endif

    unique case (state_q)
      StIdle: begin
        if (div_valid) begin
          dreg_d  = div_in;
          cnt_d   = '0;
          state_d = StNorm;
`ifdef DIVZERO_BYPASS_EN
          div_zero_d = 1'b0;
          if (div_in == '0) begin
            norm_shift_d = '0;
            div_zero_d   = 1'b1;
            state_d      = StResp;
          end
`endif
        end
      end
      StNorm: begin
        // Stops at the MSB or at the count limit, so a zero divisor ends with cnt = W-1.
        if (dreg_q[W-1] || (cnt_q == CntMax)) begin
          state_d = StSeed;
        end else begin
          dreg_d = dreg_q << 1;
          cnt_d  = cnt_q + SHIFT_W'(1);
        end
      end
      StSeed: begin
        nr_in_d   = dreg_q;
        nr_seed_d = SEED_K0 - seed_prod_hi;
        state_d   = StWait;
      end
      StWait: begin
        // A done still asserted means the Newton stage has not re-armed yet.
        if (nr_available && !nr_done) begin
          nr_start_d = 1'b1;
          state_d    = StLaunch;
        end
      end
      StLaunch: begin
        if (nr_done) begin
          nr_start_d   = 1'b0;
          norm_shift_d = cnt_q;
          state_d      = StResp;
        end
      end
      StResp: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= StIdle;
      dreg_q       <= '0;
      cnt_q        <= '0;
      nr_in_q      <= '0;
      nr_seed_q    <= '0;
      nr_start_q   <= 1'b0;
      norm_shift_q <= '0;
`ifdef DIVZERO_BYPASS_EN
      div_zero_q   <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      dreg_q       <= dreg_d;
      cnt_q        <= cnt_d;
      nr_in_q      <= nr_in_d;
      nr_seed_q    <= nr_seed_d;
      nr_start_q   <= nr_start_d;
      norm_shift_q <= norm_shift_d;
`ifdef DIVZERO_BYPASS_EN
      div_zero_q   <= div_zero_d;
`endif
    end
  end

  assign div_ready  = (state_q == StIdle);
  assign busy       = (state_q != StIdle);
  assign norm_valid = (state_q == StResp);
  assign nr_start   = nr_start_q;
  assign nr_in      = nr_in_q;
  assign nr_seed    = nr_seed_q;
  assign norm_shift = norm_shift_q;
`ifdef DIVZERO_BYPASS_EN
  assign div_zero   = div_zero_q;
`endif

endmodule

// File: tb/tb_divisor_normalizer.sv
// Testbench for divisor_normalizer: directed spec cases, randomized divisors against a
// reference model, delayed Newton availability, done-while-waiting, reset during launch.
module tb_divisor_normalizer;

  localparam logic [31:0] K0 = 32'hB4B4B4B4;
  localparam logic [31:0] K1 = 32'h78787878;

  logic        clk = 1'b0;
  logic        rstn;
  logic        div_valid;
  logic        div_ready;
  logic [31:0] div_in;
  logic        nr_start;
  logic [31:0] nr_in;
  logic [31:0] nr_seed;
  logic        nr_available;
  logic        nr_done;
  logic [4:0]  norm_shift;
  logic        norm_valid;
  logic        busy;
`ifdef DIVZERO_BYPASS_EN
  logic        div_zero;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  divisor_normalizer dut (
    .clk          (clk),
    .rstn         (rstn),
    .div_valid    (div_valid),
    .div_ready    (div_ready),
    .div_in       (div_in),
    .nr_start     (nr_start),
    .nr_in        (nr_in),
    .nr_seed      (nr_seed),
    .nr_available (nr_available),
    .nr_done      (nr_done),
    .norm_shift   (norm_shift),
    .norm_valid   (norm_valid),
    .busy         (busy)
`ifdef DIVZERO_BYPASS_EN
    ,
    .div_zero     (div_zero)
`endif
  );

  // Normalize by locating the most significant set bit; seed from 64-bit arithmetic.
  function automatic void ref_model(input logic [31:0] d, output logic [31:0] dn,
                                    output logic [31:0] seed, output int sh);
    longint unsigned p;
    int msb;
    msb = -1;
    for (int i = 0; i < 32; i++) if (d[i]) msb = i;
    if (msb < 0) begin
      sh = 31;
      dn = '0;
    end else begin
      sh = 31 - msb;
      dn = d << sh;
    end
    p    = longint'(K1) * longint'(dn);
    seed = K0 - 32'(p >> 32);
  endfunction

  // Drives one full transaction and records what was observed.
  task automatic do_txn(input logic [31:0] d, input int release_edge, output int start_edge,
                        output logic [31:0] got_in, output logic [31:0] got_seed,
                        output logic [4:0] got_shift, output bit stable_ok,
                        output bit resp_ok, output bit idle_ok);
    int edges;
    int hold;
    start_edge = -1;
    stable_ok  = 1'b1;
    resp_ok    = 1'b0;
    idle_ok    = 1'b0;
    got_in     = '0;
    got_seed   = '0;
    got_shift  = '0;
    nr_done      = 1'b0;
    nr_available = (release_edge == 0);
    @(negedge clk);
    div_valid = 1'b1;
    div_in    = d;
    @(posedge clk);
    #1;
    div_in = ~d;  // keep offering other data while busy; must be ignored
    edges = 0;
    while (edges < 200 && start_edge < 0) begin
      @(posedge clk);
      #1;
      edges++;
      if (nr_start === 1'b1) start_edge = edges;
      else if (edges == release_edge) nr_available = 1'b1;
    end
    div_valid = 1'b0;
    if (start_edge >= 0) begin
      got_in   = nr_in;
      got_seed = nr_seed;
      hold = $urandom_range(1, 4);
      repeat (hold) begin
        @(posedge clk);
        #1;
        if (nr_start !== 1'b1 || nr_in !== got_in || nr_seed !== got_seed ||
            norm_valid !== 1'b0) stable_ok = 1'b0;
      end
      nr_done = 1'b1;
      @(posedge clk);
      #1;
      nr_done   = 1'b0;
      resp_ok   = (nr_start === 1'b0 && norm_valid === 1'b1 && busy === 1'b1);
      got_shift = norm_shift;
      @(posedge clk);
      #1;
      idle_ok = (norm_valid === 1'b0 && busy === 1'b0 && div_ready === 1'b1);
    end
    nr_available = 1'b1;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    div_valid = 1'b0;
    div_in = '0;
    nr_available = 1'b0;
    nr_done = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({div_ready, busy, nr_start, norm_valid} !== 4'b1000) begin
      n_errors++;
      $display("FAIL reset_ctrl: got rdy/busy/start/valid=%b want 1000",
               {div_ready, busy, nr_start, norm_valid});
    end
    n_checks++;
    if (nr_in !== 32'h0 || nr_seed !== 32'h0 || norm_shift !== 5'h0) begin
      n_errors++;
      $display("FAIL reset_data: got in=%h seed=%h shift=%0d want 0", nr_in, nr_seed, norm_shift);
    end
    @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic test_directed();
    logic [31:0] ds [3]    = '{32'h80000000, 32'h1, 32'h3};
    logic [31:0] ein [3]   = '{32'h80000000, 32'h80000000, 32'hC0000000};
    logic [31:0] eseed [3] = '{32'h78787878, 32'h78787878, 32'h5A5A5A5A};
    int          esh [3]   = '{0, 31, 30};
    int se;
    logic [31:0] gi, gs;
    logic [4:0] gsh;
    bit st, rs, id;
    for (int i = 0; i < 3; i++) begin
      do_txn(ds[i], 0, se, gi, gs, gsh, st, rs, id);
      n_checks++;
      if (se != esh[i] + 3) begin
        n_errors++;
        $display("FAIL directed_latency d=%h: got %0d edges want %0d", ds[i], se, esh[i] + 3);
      end
      n_checks++;
      if (gi !== ein[i] || gs !== eseed[i]) begin
        n_errors++;
        $display("FAIL directed_operands d=%h: got in=%h seed=%h want in=%h seed=%h",
                 ds[i], gi, gs, ein[i], eseed[i]);
      end
      n_checks++;
      if (int'(gsh) != esh[i] || !rs) begin
        n_errors++;
        $display("FAIL directed_resp d=%h: got shift=%0d resp_ok=%0d want shift=%0d resp_ok=1",
                 ds[i], gsh, rs, esh[i]);
      end
      n_checks++;
      if (!st || !id) begin
        n_errors++;
        $display("FAIL directed_handshake d=%h: got stable=%0d idle=%0d want 1 1", ds[i], st, id);
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] d, en, es, gi, gs;
    logic [4:0] gsh;
    int esh, se;
    bit st, rs, id;
    for (int i = 0; i < 24; i++) begin
      d = $urandom() >> $urandom_range(0, 31);
      if (i == 5) d = 32'hFFFFFFFF;
`ifdef DIVZERO_BYPASS_EN
      if (d == 32'h0) d = 32'h1;
`endif
      ref_model(d, en, es, esh);
      do_txn(d, 0, se, gi, gs, gsh, st, rs, id);
      n_checks++;
      if (se != esh + 3 || gi !== en || gs !== es || int'(gsh) != esh) begin
        n_errors++;
        $display("FAIL random d=%h: got lat=%0d in=%h seed=%h sh=%0d want %0d %h %h %0d",
                 d, se, gi, gs, gsh, esh + 3, en, es, esh);
      end
      n_checks++;
      if (!st || !rs || !id) begin
        n_errors++;
        $display("FAIL random_handshake d=%h: got stable/resp/idle=%0d%0d%0d want 111",
                 d, st, rs, id);
      end
    end
  endtask

  task automatic test_hold_available();
    logic [31:0] d, en, es, gi, gs;
    logic [4:0] gsh;
    int esh, se, rel;
    bit st, rs, id;
    d = ($urandom() | 32'h1) >> $urandom_range(0, 20);
    ref_model(d, en, es, esh);
    rel = esh + 2 + 10;
    do_txn(d, rel, se, gi, gs, gsh, st, rs, id);
    n_checks++;
    if (se != rel + 1) begin
      n_errors++;
      $display("FAIL hold_available_start d=%h: got start edge %0d want %0d", d, se, rel + 1);
    end
    n_checks++;
    if (gi !== en || gs !== es || int'(gsh) != esh || !st || !rs || !id) begin
      n_errors++;
      $display("FAIL hold_available_data d=%h: got in=%h seed=%h sh=%0d st=%0d want %h %h %0d 1",
               d, gi, gs, gsh, st, en, es, esh);
    end
  endtask

  // nr_done is high from acceptance (ignored in NORM/SEED) and together with nr_available in
  // WAIT, which must not launch.
  task automatic test_wait_done();
    logic [31:0] d, en, es;
    int esh;
    bit early;
    d = 32'h00F0_1234;
    ref_model(d, en, es, esh);
    early = 1'b0;
    nr_available = 1'b1;
    nr_done = 1'b1;
    @(negedge clk);
    div_valid = 1'b1;
    div_in = d;
    @(posedge clk);
    #1;
    div_valid = 1'b0;
    repeat (esh + 2 + 4) begin
      @(posedge clk);
      #1;
      if (nr_start !== 1'b0) early = 1'b1;
    end
    nr_done = 1'b0;
    n_checks++;
    if (early || busy !== 1'b1) begin
      n_errors++;
      $display("FAIL wait_done_hold: got early=%0d busy=%0d want 0 1", early, busy);
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (nr_start !== 1'b1 || nr_in !== en || nr_seed !== es) begin
      n_errors++;
      $display("FAIL wait_done_launch: got start=%0d in=%h seed=%h want 1 %h %h",
               nr_start, nr_in, nr_seed, en, es);
    end
    nr_done = 1'b1;
    @(posedge clk);
    #1;
    nr_done = 1'b0;
    n_checks++;
    if (norm_valid !== 1'b1 || int'(norm_shift) != esh) begin
      n_errors++;
      $display("FAIL wait_done_resp: got valid=%0d shift=%0d want 1 %0d",
               norm_valid, norm_shift, esh);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_during_launch();
    logic [31:0] en, es, gi, gs;
    logic [4:0] gsh;
    int esh, se, cnt;
    bit st, rs, id;
    nr_available = 1'b1;
    nr_done = 1'b0;
    @(negedge clk);
    div_valid = 1'b1;
    div_in = 32'h0000_0F00;
    @(posedge clk);
    #1;
    div_valid = 1'b0;
    cnt = 0;
    while (nr_start !== 1'b1 && cnt < 60) begin
      @(posedge clk);
      #1;
      cnt++;
    end
    n_checks++;
    if (nr_start !== 1'b1) begin
      n_errors++;
      $display("FAIL rst_launch_reach: got start=%0d want 1", nr_start);
    end
    #2;
    rstn = 1'b0;
    #1;
    n_checks++;
    if ({nr_start, busy, norm_valid, div_ready} !== 4'b0001) begin
      n_errors++;
      $display("FAIL rst_launch_drop: got start/busy/valid/rdy=%b want 0001",
               {nr_start, busy, norm_valid, div_ready});
    end
    @(negedge clk);
    rstn = 1'b1;
    ref_model(32'h0000_0003, en, es, esh);
    do_txn(32'h0000_0003, 0, se, gi, gs, gsh, st, rs, id);
    n_checks++;
    if (se != esh + 3 || gi !== en || gs !== es || int'(gsh) != esh || !rs || !id) begin
      n_errors++;
      $display("FAIL rst_launch_next: got lat=%0d in=%h seed=%h sh=%0d want %0d %h %h %0d",
               se, gi, gs, gsh, esh + 3, en, es, esh);
    end
  endtask

  task automatic test_zero_divisor();
`ifdef DIVZERO_BYPASS_EN
    bit started;
    started = 1'b0;
    nr_available = 1'b1;
    @(negedge clk);
    div_valid = 1'b1;
    div_in = 32'h0;
    @(posedge clk);
    #1;
    div_valid = 1'b0;
    if (nr_start !== 1'b0) started = 1'b1;
    n_checks++;
    if ({norm_valid, div_zero, busy} !== 3'b111 || norm_shift !== 5'd0) begin
      n_errors++;
      $display("FAIL zero_bypass_resp: got valid/zero/busy=%b shift=%0d want 111 0",
               {norm_valid, div_zero, busy}, norm_shift);
    end
    repeat (3) begin
      @(posedge clk);
      #1;
      if (nr_start !== 1'b0) started = 1'b1;
    end
    n_checks++;
    if (started || busy !== 1'b0 || norm_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL zero_bypass_after: got started=%0d busy=%0d valid=%0d want 0 0 0",
               started, busy, norm_valid);
    end
`else
    logic [31:0] gi, gs;
    logic [4:0] gsh;
    int se;
    bit st, rs, id;
    do_txn(32'h0, 0, se, gi, gs, gsh, st, rs, id);
    n_checks++;
    if (se != 34 || gi !== 32'h0 || gs !== K0 || gsh !== 5'd31 || !rs || !id) begin
      n_errors++;
      $display("FAIL zero_normal: got lat=%0d in=%h seed=%h sh=%0d want 34 0 %h 31",
               se, gi, gs, gsh, K0);
    end
`endif
  endtask

  task automatic test_back_to_back();
    logic [31:0] d, en, es, gi, gs;
    logic [4:0] gsh;
    int esh, se;
    bit st, rs, id;
    for (int i = 0; i < 3; i++) begin
      d = 32'h1 << (i * 11);
      ref_model(d, en, es, esh);
      do_txn(d, 0, se, gi, gs, gsh, st, rs, id);
      n_checks++;
      if (se != esh + 3 || gi !== en || gs !== es || int'(gsh) != esh || !st || !rs || !id) begin
        n_errors++;
        $display("FAIL back_to_back d=%h: got lat=%0d in=%h seed=%h sh=%0d want %0d %h %h %0d",
                 d, se, gi, gs, gsh, esh + 3, en, es, esh);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_hold_available();
    test_wait_done();
    test_reset_during_launch();
    test_zero_divisor();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
